// File: rtl/br_predictor_btb.sv
// br_predictor_btb: direct-mapped BTB with saturating direction counters for the fetch stage.
// Optional global-history index hashing is enabled by defining BP_GSHARE_EN.
`default_nettype none

module br_predictor_btb #(
   parameter int WORD_W   = 32,
   parameter int IDX_BITS = 4,
   parameter int TAG_BITS = 8,
   parameter int CTR_BITS = 2,
   parameter int GHR_BITS = 4
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [WORD_W-1:0]   lookup_pc,
   output logic                predict,
   output logic                hit,
   output logic [WORD_W-1:0]   pred_target,
   output logic [IDX_BITS-1:0] index_O,
   input  logic                update_en,
   input  logic [WORD_W-1:0]   update_pc,
   input  logic [IDX_BITS-1:0] update_index,
   input  logic                update_taken,
   input  logic [WORD_W-1:0]   update_target,
   input  logic                flush
);

   localparam int ENTRIES = 2 ** IDX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

   logic                valid_q [ENTRIES];
   logic [TAG_BITS-1:0] tag_q   [ENTRIES];
   logic [WORD_W-1:0]   tgt_q   [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

   logic [IDX_BITS-1:0] pc_idx;
   logic [IDX_BITS-1:0] lkp_idx;
   logic [TAG_BITS-1:0] lkp_tag;
   logic [TAG_BITS-1:0] upd_tag;
   logic                upd_hit;
   logic                wr_en;
   logic [TAG_BITS-1:0] tag_d;
   logic [WORD_W-1:0]   tgt_d;
   logic [CTR_BITS-1:0] ctr_d;

   assign pc_idx  = lookup_pc[IDX_BITS+1:2];
   assign lkp_tag = lookup_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
   assign upd_tag = update_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

`ifdef BP_GSHARE_EN
   logic [GHR_BITS-1:0] ghr_q;

   assign lkp_idx = pc_idx ^ IDX_BITS'(ghr_q);

   // History shifts on every resolved branch; flush clears it and drops the update.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ghr_q <= '0;
      end else if (flush) begin
         ghr_q <= '0;
      end else if (update_en) begin
         ghr_q <= GHR_BITS'({ghr_q, update_taken});
      end
   end
`else
   logic [GHR_BITS-1:0] unused_ghr_w;

   assign unused_ghr_w = '0;
   assign lkp_idx      = pc_idx;
`endif

   assign index_O     = lkp_idx;
   assign hit         = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
   assign predict     = hit && ctr_q[lkp_idx][CTR_BITS-1];
   assign pred_target = hit ? tgt_q[lkp_idx] : '0;

   assign upd_hit = valid_q[update_index] && (tag_q[update_index] == upd_tag);

   always_comb begin
      wr_en = 1'b0;
      tag_d = tag_q[update_index];
      tgt_d = tgt_q[update_index];
      ctr_d = ctr_q[update_index];
      if (update_en) begin
         if (upd_hit) begin
            wr_en = 1'b1;
            if (update_taken) begin
               tgt_d = update_target;
               if (ctr_q[update_index] != CTR_MAX) ctr_d = ctr_q[update_index] + 1'b1;
            end else begin
               if (ctr_q[update_index] != '0) ctr_d = ctr_q[update_index] - 1'b1;
            end
         end else if (update_taken) begin
            // Only taken branches earn an entry; a not-taken miss leaves the table alone.
            wr_en = 1'b1;
            tag_d = upd_tag;
            tgt_d = update_target;
            ctr_d = CTR_WEAK;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (wr_en) begin
         valid_q[update_index] <= 1'b1;
         tag_q[update_index]   <= tag_d;
         tgt_q[update_index]   <= tgt_d;
         ctr_q[update_index]   <= ctr_d;
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[WORD_W-1:IDX_BITS+TAG_BITS+2],
                             update_pc[IDX_BITS+1:0], update_pc[WORD_W-1:IDX_BITS+TAG_BITS+2]};

endmodule

`default_nettype wire

// File: tb/tb_br_predictor_btb.sv
// Directed self-checking bench for br_predictor_btb (default parameters, no history hashing).
`default_nettype none

module tb_br_predictor_btb;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] lookup_pc;
   logic        predict;
   logic        hit;
   logic [31:0] pred_target;
   logic [3:0]  index_O;
   logic        update_en;
   logic [31:0] update_pc;
   logic [3:0]  update_index;
   logic        update_taken;
   logic [31:0] update_target;
   logic        flush;

   int n_vec = 0;
   int n_err = 0;

   br_predictor_btb dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .lookup_pc    (lookup_pc),
      .predict      (predict),
      .hit          (hit),
      .pred_target  (pred_target),
      .index_O      (index_O),
      .update_en    (update_en),
      .update_pc    (update_pc),
      .update_index (update_index),
      .update_taken (update_taken),
      .update_target(update_target),
      .flush        (flush)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic [3:0] idx,
                            input logic taken, input logic [31:0] tgt);
      update_en     = 1'b1;
      update_pc     = pc;
      update_index  = idx;
      update_taken  = taken;
      update_target = tgt;
      tick();
      update_en     = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic e_hit,
                       input logic e_pred, input logic [31:0] e_tgt);
      lookup_pc = pc;
      #1;
      check({tag, ".hit"},    {31'd0, hit},     {31'd0, e_hit});
      check({tag, ".pred"},   {31'd0, predict}, {31'd0, e_pred});
      check({tag, ".target"}, pred_target,      e_tgt);
   endtask

   initial begin
      nRST = 1'b0; lookup_pc = '0; update_en = 1'b0; update_pc = '0;
      update_index = '0; update_taken = 1'b0; update_target = '0; flush = 1'b0;
      repeat (2) tick();
      nRST = 1'b1;
      tick();

      // Reset: every index empty
      for (int i = 0; i < 16; i++) begin
         lookup_pc = 32'h40 | (i << 2);
         #1;
         check("reset.hit", {31'd0, hit}, 32'd0);
         check("reset.idx", {28'd0, index_O}, i);
      end
      look("reset", 32'h40, 1'b0, 1'b0, 32'h0);

      // Allocate
      do_update(32'h40, 4'd0, 1'b1, 32'h100);
      look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
      look("alias", 32'h440, 1'b0, 1'b0, 32'h0);

      // Update inputs are ignored while update_en is low
      update_pc = 'x; update_index = 'x; update_taken = 1'bx; update_target = 'x;
      tick();
      look("xidle", 32'h40, 1'b1, 1'b1, 32'h100);

      // Saturation: 2 -> 3 -> 3 -> 3, then 2
      repeat (3) do_update(32'h40, 4'd0, 1'b1, 32'h200);
      do_update(32'h40, 4'd0, 1'b0, 32'hDEAD);
      look("sat.nt1", 32'h40, 1'b1, 1'b1, 32'h200);
      repeat (2) do_update(32'h40, 4'd0, 1'b0, 32'hDEAD);
      look("sat.nt3", 32'h40, 1'b1, 1'b0, 32'h200);
      repeat (5) do_update(32'h40, 4'd0, 1'b0, 32'hDEAD);
      do_update(32'h40, 4'd0, 1'b1, 32'h200);
      look("sat.low", 32'h40, 1'b1, 1'b0, 32'h200);

      // Not-taken miss on index 0 (tag 2) leaves the resident entry alone
      do_update(32'h80, 4'd0, 1'b0, 32'h900);
      look("ntmiss", 32'h80, 1'b0, 1'b0, 32'h0);
      look("ntkeep", 32'h40, 1'b1, 1'b0, 32'h200);

      // Same-cycle collision: counter 1 -> 2, then not-taken while looking up
      do_update(32'h40, 4'd0, 1'b1, 32'h200);
      lookup_pc = 32'h40;
      update_en = 1'b1; update_pc = 32'h40; update_index = 4'd0;
      update_taken = 1'b0; update_target = 32'h0;
      #1;
      check("coll.pre", {31'd0, predict}, 32'd1);
      tick();
      update_en = 1'b0;
      look("coll.post", 32'h40, 1'b1, 1'b0, 32'h200);

      // Flush beats a simultaneous update to index 3
      do_update(32'h54, 4'd5, 1'b1, 32'h300);
      look("pre.flush", 32'h54, 1'b1, 1'b1, 32'h300);
      flush = 1'b1;
      do_update(32'h4C, 4'd3, 1'b1, 32'h400);
      flush = 1'b0;
      look("flush.i0", 32'h40, 1'b0, 1'b0, 32'h0);
      look("flush.i5", 32'h54, 1'b0, 1'b0, 32'h0);
      look("flush.i3", 32'h4C, 1'b0, 1'b0, 32'h0);
      do_update(32'h40, 4'd0, 1'b1, 32'h500);
      look("realloc", 32'h40, 1'b1, 1'b1, 32'h500);

      // Asynchronous reset takes effect without a clock edge
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      check("async.hit", {31'd0, hit}, 32'd0);
      check("async.tgt", pred_target, 32'd0);
      tick();
      nRST = 1'b1;
      tick();
      look("post.rst", 32'h40, 1'b0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
